// File: rtl/tiny_bus_target.sv
// tiny_bus_target: responder for the tinycpu external bus.
// Decodes ADDRESS/RW each cycle, serves hits from a small scratch RAM or a
// four-byte timer register window, stalls the CPU through RDY for
// WAIT_STATES cycles per access and raises IRQ when the timer expires.
module tiny_bus_target #(
    parameter logic [15:0] RAM_BASE    = 16'h0000,
    parameter int          RAM_DEPTH   = 32,
    parameter logic [15:0] IO_BASE     = 16'hFF00,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] ADDRESS,
    input  logic        RW,
    input  logic [7:0]  CPU_DATA_OUT,
    output logic [7:0]  CPU_DATA_IN,
    output logic        RDY,
    output logic        IRQ
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         AW       = $clog2(RAM_DEPTH);
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LAST  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    // Register offsets inside the timer window.
    localparam logic [1:0] OFF_RELOAD = 2'd0;
    localparam logic [1:0] OFF_COUNT  = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;

    logic          ram_hit;
    logic          io_hit;
    logic          hit;
    logic [AW-1:0] ram_idx;
    logic [1:0]    io_off;

    logic          complete;
    logic          ram_we;
    logic          io_we;
    logic          rd_en;
    logic          reload_we;
    logic          ctrl_we;
    logic          status_we;

    logic [7:0]    ram [RAM_DEPTH];
    logic [7:0]    reload;
    logic [7:0]    count;
    ctrl_t         ctrl;
    logic          exp_flag;
    logic          expire;

    logic [7:0]    io_rd_data;
    logic [7:0]    rd_data;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Both regions are naturally aligned, so a hit is an upper-bit compare
    // and the RAM offset (ADDRESS - RAM_BASE) is simply the low AW bits.
    // NOTE: every signal assigned in an always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        ram_hit = (ADDRESS[15:AW] == RAM_BASE[15:AW]);
        io_hit  = (ADDRESS[15:2] == IO_BASE[15:2]) && !ram_hit;
        hit     = ram_hit || io_hit;
        ram_idx = ADDRESS[AW-1:0];
        io_off  = ADDRESS[1:0];
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    // State register: stall counter and access phase.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a hit in IDLE opens the stall window, WAIT counts it down.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (hit && HAS_WAIT) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WS_LAST;
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: RDY is low only while stalling; completion marks the final cycle.
    always_comb begin
        RDY      = 1'b1;
        complete = 1'b0;
        if (!RST) begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        if (HAS_WAIT) begin
                            RDY = 1'b0;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        RDY = 1'b0;
                    end
                end
                default: begin
                    RDY      = 1'b1;
                    complete = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completion strobes
    // ------------------------------------------------------------------
    // The completing cycle's ADDRESS/RW decide what happens; a miss does nothing.
    always_comb begin
        ram_we    = complete && !RW && ram_hit;
        io_we     = complete && !RW && io_hit;
        rd_en     = complete && RW && hit;
        reload_we = io_we && (io_off == OFF_RELOAD);
        ctrl_we   = io_we && (io_off == OFF_CTRL);
        status_we = io_we && (io_off == OFF_STATUS);
    end

    // ------------------------------------------------------------------
    // Scratch RAM
    // ------------------------------------------------------------------
    // RAM write port.
    // NOTE: the RAM array is deliberately not reset so it maps onto a plain memory macro.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= CPU_DATA_OUT;
        end
    end

    // ------------------------------------------------------------------
    // Timer registers
    // ------------------------------------------------------------------
    // Expiry: the counter sits at zero while the timer is enabled.
    always_comb begin
        expire = ctrl.en && (count == 8'd0);
    end

    // RELOAD and COUNT: a RELOAD write loads both and overrides the timer step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reload <= 8'h00;
            count  <= 8'h00;
        end else begin
            if (reload_we) begin
                reload <= CPU_DATA_OUT;
                count  <= CPU_DATA_OUT;
            end else if (ctrl.en) begin
                if (count != 8'd0) begin
                    count <= count - 8'd1;
                end else if (ctrl.auto_reload) begin
                    count <= reload;
                end
            end
        end
    end

    // CTRL: a write wins over the one-shot auto-clear of EN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= ctrl_t'(CPU_DATA_OUT[2:0]);
        end else if (expire && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    // STATUS.EXP: set on expiry, write-one-to-clear; set wins on a tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (status_we && CPU_DATA_OUT[0]) begin
            exp_flag <= 1'b0;
        end
    end

    // Interrupt is a level straight from the registers.
    always_comb begin
        IRQ = exp_flag && ctrl.irq_en;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Read mux: register window with unused bits reading as zero, else RAM.
    always_comb begin
        io_rd_data = 8'h00;
        case (io_off)
            OFF_RELOAD: io_rd_data = reload;
            OFF_COUNT:  io_rd_data = count;
            OFF_CTRL:   io_rd_data = {5'b0, ctrl};
            OFF_STATUS: io_rd_data = {7'b0, exp_flag};
            default:    io_rd_data = 8'h00;
        endcase
        rd_data = ram_hit ? ram[ram_idx] : io_rd_data;
    end

    // Returned data register: updates only on a completed read hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CPU_DATA_IN <= 8'h00;
        end else if (rd_en) begin
            CPU_DATA_IN <= rd_data;
        end
    end

endmodule

// File: tb/tb_tiny_bus_target.sv
// Self-checking bench for tiny_bus_target: three instances with 2, 0 and 3
// wait states, directed scenarios followed by random bus traffic, all checked
// against a behavioural model of the RAM, timer and bus protocol.
module tb_tiny_bus_target;

    localparam int RB = 'h0000;
    localparam int RD = 32;
    localparam int IB = 'hFF00;

    logic        clk = 1'b0;
    logic        t_rst  [3];
    logic [15:0] t_addr [3];
    logic        t_rw   [3];
    logic [7:0]  t_wd   [3];
    logic [7:0]  din    [3];
    logic [2:0]  rdy;
    logic [2:0]  irq;

    // Stimulus-side expectations for the current cycle.
    bit          e_rdy  [3];
    bit          t_comp [3];

    // Behavioural model state.
    logic [7:0]  m_ram    [3][256];
    logic [7:0]  m_reload [3];
    logic [7:0]  m_count  [3];
    logic [7:0]  m_din    [3];
    bit          m_en     [3];
    bit          m_ie     [3];
    bit          m_auto   [3];
    bit          m_exp    [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tiny_bus_target #(.RAM_BASE(16'h0000), .RAM_DEPTH(32), .IO_BASE(16'hFF00), .WAIT_STATES(2)) u_ws2 (
        .CLK(clk), .RST(t_rst[0]), .ADDRESS(t_addr[0]), .RW(t_rw[0]),
        .CPU_DATA_OUT(t_wd[0]), .CPU_DATA_IN(din[0]), .RDY(rdy[0]), .IRQ(irq[0])
    );
    tiny_bus_target #(.RAM_BASE(16'h0000), .RAM_DEPTH(32), .IO_BASE(16'hFF00), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RST(t_rst[1]), .ADDRESS(t_addr[1]), .RW(t_rw[1]),
        .CPU_DATA_OUT(t_wd[1]), .CPU_DATA_IN(din[1]), .RDY(rdy[1]), .IRQ(irq[1])
    );
    tiny_bus_target #(.RAM_BASE(16'h0000), .RAM_DEPTH(32), .IO_BASE(16'hFF00), .WAIT_STATES(3)) u_ws3 (
        .CLK(clk), .RST(t_rst[2]), .ADDRESS(t_addr[2]), .RW(t_rw[2]),
        .CPU_DATA_OUT(t_wd[2]), .CPU_DATA_IN(din[2]), .RDY(rdy[2]), .IRQ(irq[2])
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit is_ram(input logic [15:0] a);
        return (int'(a) >= RB) && (int'(a) < RB + RD);
    endfunction

    function automatic bit is_io(input logic [15:0] a);
        return (int'(a) >= IB) && (int'(a) <= IB + 3);
    endfunction

    function automatic logic [7:0] io_read(input int d, input int off);
        case (off)
            0:       return m_reload[d];
            1:       return m_count[d];
            2:       return {5'b0, m_auto[d], m_ie[d], m_en[d]};
            default: return {7'b0, m_exp[d]};
        endcase
    endfunction

    // Apply one clock edge to the model of instance d.
    task automatic model_edge(input int d);
        logic [7:0] cnt_n;
        bit         en_n;
        bit         exp_n;
        bit         expire;
        int         off;
        if (t_rst[d]) begin
            m_reload[d] = 8'h00; m_count[d] = 8'h00; m_din[d] = 8'h00;
            m_en[d] = 0; m_ie[d] = 0; m_auto[d] = 0; m_exp[d] = 0;
            return;
        end
        expire = m_en[d] && (m_count[d] == 8'h00);
        cnt_n  = m_count[d];
        en_n   = m_en[d];
        exp_n  = m_exp[d];
        if (m_en[d]) begin
            if (m_count[d] != 8'h00) begin
                cnt_n = m_count[d] - 8'd1;
            end else begin
                exp_n = 1;
                if (m_auto[d]) cnt_n = m_reload[d];
                else           en_n  = 0;
            end
        end
        if (t_comp[d]) begin
            if (is_ram(t_addr[d])) begin
                off = int'(t_addr[d]) - RB;
                if (t_rw[d]) m_din[d] = m_ram[d][off];
                else         m_ram[d][off] = t_wd[d];
            end else if (is_io(t_addr[d])) begin
                off = int'(t_addr[d]) - IB;
                if (t_rw[d]) begin
                    m_din[d] = io_read(d, off);
                end else begin
                    case (off)
                        0: begin m_reload[d] = t_wd[d]; cnt_n = t_wd[d]; end
                        2: begin en_n = t_wd[d][0]; m_ie[d] = t_wd[d][1]; m_auto[d] = t_wd[d][2]; end
                        3: if (t_wd[d][0] && !expire) exp_n = 0;
                        default: ;
                    endcase
                end
            end
        end
        m_count[d] = cnt_n;
        m_en[d]    = en_n;
        m_exp[d]   = exp_n;
    endtask

    // One bus cycle: check RDY mid-cycle, step the model, check registered outputs.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("rdy%0d", d), 16'(rdy[d]), 16'(e_rdy[d]));
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("din%0d", d), 16'(din[d]), 16'(m_din[d]));
            check($sformatf("irq%0d", d), 16'(irq[d]), 16'(m_exp[d] && m_ie[d]));
        end
    endtask

    task automatic go_idle(input int d);
        t_addr[d] = 16'h8000; t_rw[d] = 1'b1; t_wd[d] = 8'h00;
        t_comp[d] = 0; e_rdy[d] = 1;
    endtask

    // Full access on instance d: WAIT_STATES stalled cycles, then completion.
    task automatic access(input int d, input logic rw_v, input logic [15:0] a, input logic [7:0] wd);
        int n;
        n = (is_ram(a) || is_io(a)) ? ws_of(d) : 0;
        t_addr[d] = a; t_rw[d] = rw_v; t_wd[d] = wd;
        for (int k = 0; k <= n; k++) begin
            e_rdy[d]  = (k == n);
            t_comp[d] = (k == n);
            tick();
        end
        go_idle(d);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  held;
        int          d;
        int          kind;

        for (int i = 0; i < 3; i++) begin
            t_rst[i] = 1'b1;
            go_idle(i);
        end
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) t_rst[i] = 1'b0;

        // Registers read back as zero out of reset.
        for (int r = 0; r < 4; r++) begin
            access(0, 1'b1, 16'(IB + r), 8'h00);
            check("reset_reg", 16'(din[0]), 16'h0000);
        end

        // Give every RAM byte a known value.
        for (int i = 0; i < 3; i++)
            for (int r = 0; r < RD; r++) access(i, 1'b0, 16'(RB + r), 8'($urandom));

        // Two-wait-state write then read.
        access(0, 1'b0, 16'h0005, 8'hA5);
        access(0, 1'b1, 16'h0005, 8'h00);
        check("ws2_read", 16'(din[0]), 16'h00A5);

        // Zero-wait-state back-to-back write/read of the last RAM byte.
        access(1, 1'b0, 16'h001F, 8'h3C);
        access(1, 1'b1, 16'h001F, 8'h00);
        check("ws0_read", 16'(din[1]), 16'h003C);

        // Misses: no stall, no data change, no store.
        access(1, 1'b1, 16'h8000, 8'h00);
        check("miss_rd_din", 16'(din[1]), 16'h003C);
        access(1, 1'b0, 16'h8000, 8'hEE);
        access(1, 1'b1, 16'h001F, 8'h00);
        check("miss_no_store", 16'(din[1]), 16'h003C);
        access(1, 1'b1, 16'hFF00, 8'h00);
        check("miss_reload", 16'(din[1]), 16'h0000);

        // Auto-reload timer, period 4: read COUNT every cycle after edge E.
        access(1, 1'b0, 16'hFF00, 8'h03);
        access(1, 1'b0, 16'hFF02, 8'h07);
        for (int k = 1; k <= 8; k++) begin
            access(1, 1'b1, 16'hFF01, 8'h00);
            check($sformatf("count_e%0d", k), 16'(din[1]), 16'(3 - ((k - 1) % 4)));
            check($sformatf("irq_e%0d", k), 16'(irq[1]), 16'(k >= 4));
        end

        // W1C at E+9 clears, at E+12 collides with expiry (set wins), at E+13 clears.
        for (int k = 9; k <= 13; k++) begin
            if (k == 9 || k == 12 || k == 13) begin
                t_addr[1] = 16'hFF03; t_rw[1] = 1'b0; t_wd[1] = 8'h01;
                t_comp[1] = 1; e_rdy[1] = 1;
            end else begin
                go_idle(1);
            end
            tick();
            check($sformatf("w1c_e%0d", k), 16'(irq[1]), 16'(k == 12));
        end
        go_idle(1);
        access(1, 1'b0, 16'hFF02, 8'h00);
        access(1, 1'b0, 16'hFF03, 8'h01);

        // Reset in the second stall cycle of a three-wait-state write.
        access(2, 1'b0, 16'h0002, 8'h11);
        access(2, 1'b0, 16'hFF00, 8'h55);
        t_addr[2] = 16'h0002; t_rw[2] = 1'b0; t_wd[2] = 8'h77;
        t_comp[2] = 0; e_rdy[2] = 0;
        tick();
        t_rst[2] = 1'b1; e_rdy[2] = 1;
        tick();
        check("rst_din", 16'(din[2]), 16'h0000);
        t_rst[2] = 1'b0; t_rw[2] = 1'b1; e_rdy[2] = 0;
        tick();
        tick();
        tick();
        e_rdy[2] = 1; t_comp[2] = 1;
        tick();
        check("rst_no_store", 16'(din[2]), 16'h0011);
        go_idle(2);
        access(2, 1'b1, 16'hFF00, 8'h00);
        check("rst_reload", 16'(din[2]), 16'h0000);

        // Random traffic against the model.
        for (int it = 0; it < 300; it++) begin
            d    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            if (kind < 5)      a = 16'(RB + $urandom_range(0, RD - 1));
            else if (kind < 9) a = 16'(IB + $urandom_range(0, 3));
            else               a = 16'($urandom_range(32'h0020, 32'hFEFF));
            held = 8'($urandom);
            access(d, 1'($urandom), a, held);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
